// File: rtl/relu_pool_window.sv
// Applies ReLU to a raster pixel stream and assembles non-overlapping 2x2 windows per channel.
// Latency: 1 cycle from the odd/odd accepting edge to win_valid. No backpressure: in_ready stays high for the whole frame.
module relu_pool_window #(
    parameter int unsigned DATA_W  = 69,
    parameter int unsigned CH      = 8,
    parameter int unsigned IMG_W   = 24,
    parameter int unsigned IMG_H   = 24,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 win_valid,
    output logic [CH*DATA_W-1:0] win_00,
    output logic [CH*DATA_W-1:0] win_01,
    output logic [CH*DATA_W-1:0] win_10,
    output logic [CH*DATA_W-1:0] win_11,
    output logic [4:0]           count_x,
    output logic [4:0]           count_y,
    output logic                 frame_done
);
    localparam int unsigned PW = CH * DATA_W;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [PW-1:0]   prev_q;
    logic [PW-1:0]   w00_q, w00_d, w01_q, w01_d, w10_q, w10_d, w11_q, w11_d;
    logic [4:0]      cx_q, cx_d, cy_q, cy_d;
    logic            vld_q, vld_d, done_q, done_d;
    logic [PW-1:0]   pix;
    logic [PW-1:0]   linebuf [IMG_W];
    logic            xfer, last_col, last_row;

    assign xfer     = in_valid && (state_q == S_RUN);
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    always_comb begin
        pix = in_data;
        if (RELU_EN) begin
            for (int c = 0; c < int'(CH); c++) begin
                if (in_data[c*DATA_W + DATA_W - 1]) begin
                    pix[c*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        w00_d   = w00_q;
        w01_d   = w01_q;
        w10_d   = w10_q;
        w11_d   = w11_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    // Bottom-right corner of a window: the top row sits in linebuf, bottom-left in prev.
                    if (row_q[0] && col_q[0]) begin
                        vld_d  = 1'b1;
                        w00_d  = linebuf[col_q - CW'(1)];
                        w01_d  = linebuf[col_q];
                        w10_d  = prev_q;
                        w11_d  = pix;
                        cx_d   = 5'(row_q >> 1);
                        cy_d   = 5'(col_q >> 1);
                        done_d = last_row && last_col;
                    end
                    if (last_row && last_col) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            prev_q  <= '0;
            w00_q   <= '0;
            w01_q   <= '0;
            w10_q   <= '0;
            w11_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (xfer) begin
                prev_q <= pix;
            end
            w00_q   <= w00_d;
            w01_q   <= w01_d;
            w10_q   <= w10_d;
            w11_q   <= w11_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    // Line buffer contents are never read before being rewritten in a new frame, so no reset.
    always_ff @(posedge clk) begin
        if (xfer && !row_q[0]) begin
            linebuf[col_q] <= pix;
        end
    end

    assign in_ready   = (state_q == S_RUN);
    assign win_valid  = vld_q;
    assign win_00     = w00_q;
    assign win_01     = w01_q;
    assign win_10     = w10_q;
    assign win_11     = w11_q;
    assign count_x    = cx_q;
    assign count_y    = cy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_relu_pool_window.sv
// Bench for relu_pool_window: frames of directed/random pixels checked against a frame-array window model.
module tb_relu_pool_window;
    localparam int DW = 69;
    localparam int CH = 8;
    localparam int W  = 24;
    localparam int H  = 24;
    localparam int PW = CH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;

    logic          in_ready_a, win_valid_a, frame_done_a;
    logic [PW-1:0] win_00_a, win_01_a, win_10_a, win_11_a;
    logic [4:0]    count_x_a, count_y_a;
    logic          in_ready_b, win_valid_b, frame_done_b;
    logic [PW-1:0] win_00_b, win_01_b, win_10_b, win_11_b;
    logic [4:0]    count_x_b, count_y_b;

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] pix [H][W];
    localparam logic [DW-1:0] NEG5 = ~DW'(4);

    relu_pool_window #(.DATA_W(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .win_valid(win_valid_a), .win_00(win_00_a), .win_01(win_01_a),
        .win_10(win_10_a), .win_11(win_11_a), .count_x(count_x_a), .count_y(count_y_a),
        .frame_done(frame_done_a)
    );

    relu_pool_window #(.DATA_W(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .RELU_EN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .win_valid(win_valid_b), .win_00(win_00_b), .win_01(win_01_b),
        .win_10(win_10_b), .win_11(win_11_b), .count_x(count_x_b), .count_y(count_y_b),
        .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] relu(input logic [PW-1:0] p, input bit en);
        logic [PW-1:0] r;
        r = p;
        for (int c = 0; c < CH; c++) begin
            if (en && p[c*DW + DW - 1]) r[c*DW +: DW] = '0;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_px();
        logic [PW-1:0] p;
        for (int c = 0; c < CH; c++) p[c*DW +: DW] = DW'({$urandom(), $urandom(), $urandom()});
        return p;
    endfunction

    // mode 0: ramp 24*r+c, 1: ch0=+7 / ch3=-5, 2: c*1000+index, 3: random
    task automatic fill(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int x = 0; x < W; x++) begin
                logic [PW-1:0] p;
                p = rand_px();
                for (int c = 0; c < CH; c++) begin
                    case (mode)
                        0: p[c*DW +: DW] = DW'(W * r + x);
                        2: p[c*DW +: DW] = DW'(c * 1000 + r * W + x);
                        default: ;
                    endcase
                end
                if (mode == 1) begin
                    p[0 +: DW]    = DW'(7);
                    p[3*DW +: DW] = NEG5;
                end
                pix[r][x] = p;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk_s({tag, "_in_ready"}, 32'(in_ready_a), 0);
        chk_s({tag, "_win_valid"}, 32'(win_valid_a), 0);
        chk({tag, "_win_00"}, win_00_a, '0);
        chk({tag, "_win_01"}, win_01_a, '0);
        chk({tag, "_win_10"}, win_10_a, '0);
        chk({tag, "_win_11"}, win_11_a, '0);
        chk_s({tag, "_count_x"}, 32'(count_x_a), 0);
        chk_s({tag, "_count_y"}, 32'(count_y_a), 0);
        chk_s({tag, "_frame_done"}, 32'(frame_done_a), 0);
    endtask

    task automatic check_win(input int i, input int j, input bit last);
        chk_s("win_valid", 32'(win_valid_a), 1);
        chk_s("win_valid_raw", 32'(win_valid_b), 1);
        chk("win_00", win_00_a, relu(pix[2*i][2*j], 1'b1));
        chk("win_01", win_01_a, relu(pix[2*i][2*j+1], 1'b1));
        chk("win_10", win_10_a, relu(pix[2*i+1][2*j], 1'b1));
        chk("win_11", win_11_a, relu(pix[2*i+1][2*j+1], 1'b1));
        chk("win_00_raw", win_00_b, pix[2*i][2*j]);
        chk("win_01_raw", win_01_b, pix[2*i][2*j+1]);
        chk("win_10_raw", win_10_b, pix[2*i+1][2*j]);
        chk("win_11_raw", win_11_b, pix[2*i+1][2*j+1]);
        chk_s("count_x", 32'(count_x_a), 32'(i));
        chk_s("count_y", 32'(count_y_a), 32'(j));
        chk_s("frame_done", 32'(frame_done_a), 32'(last));
    endtask

    task automatic run_frame(input int gap_pct, input int abort_after, input int start_glitch_at);
        int n;
        n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_s("in_ready_run", 32'(in_ready_a), 1);
        for (int r = 0; r < H; r++) begin
            for (int x = 0; x < W; x++) begin
                while ($urandom_range(99) < gap_pct) begin
                    in_valid = 1'b0;
                    in_data  = rand_px();
                    @(posedge clk); #1;
                    chk_s("gap_no_win", 32'(win_valid_a), 0);
                end
                in_valid = 1'b1;
                in_data  = pix[r][x];
                start    = (n == start_glitch_at);
                @(posedge clk); #1;
                start    = 1'b0;
                in_valid = 1'b0;
                n++;
                if ((r % 2 == 1) && (x % 2 == 1)) begin
                    check_win(r / 2, x / 2, (r == H - 1) && (x == W - 1));
                end else begin
                    chk_s("no_win", 32'(win_valid_a), 0);
                    chk_s("no_done", 32'(frame_done_a), 0);
                end
                if (n == abort_after) begin
                    #1 rst = 1'b0;
                    #1 check_zero("abort");
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
            end
        end
        chk_s("in_ready_done", 32'(in_ready_a), 0);
        in_valid = 1'b1;
        in_data  = rand_px();
        repeat (3) begin
            @(posedge clk); #1;
            chk_s("hold_in_ready", 32'(in_ready_a), 0);
            chk_s("hold_win_valid", 32'(win_valid_a), 0);
            chk_s("hold_count_x", 32'(count_x_a), H / 2 - 1);
            chk_s("hold_count_y", 32'(count_y_a), W / 2 - 1);
            chk_s("hold_frame_done", 32'(frame_done_a), 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // in_valid while idle must not move anything
        in_valid = 1'b1;
        in_data  = rand_px();
        repeat (4) begin
            @(posedge clk); #1;
            chk_s("idle_in_ready", 32'(in_ready_a), 0);
            chk_s("idle_win_valid", 32'(win_valid_a), 0);
            chk_s("idle_count_x", 32'(count_x_a), 0);
            chk_s("idle_count_y", 32'(count_y_a), 0);
        end
        in_valid = 1'b0;

        // ramp frame, no gaps, with a start pulse mid-frame
        fill(0);
        run_frame(0, -1, 100);
        chk_s("ramp_last_00", 32'(win_00_a[DW-1:0]), 550);
        chk_s("ramp_last_01", 32'(win_01_a[DW-1:0]), 551);
        chk_s("ramp_last_10", 32'(win_10_a[DW-1:0]), 574);
        chk_s("ramp_last_11", 32'(win_11_a[DW-1:0]), 575);

        // ReLU clamp vs pass-through
        fill(1);
        run_frame(0, -1, -1);
        chk("relu_ch3", PW'(win_11_a[3*DW +: DW]), '0);
        chk("raw_ch3", PW'(win_11_b[3*DW +: DW]), PW'(NEG5));

        // channel packing with random gaps
        fill(2);
        run_frame(50, -1, -1);

        // ramp again with gaps
        fill(0);
        run_frame(50, -1, -1);

        // mid-frame reset after 300 pixels, then a fresh random frame
        fill(3);
        run_frame(0, 300, -1);
        fill(3);
        run_frame(30, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/relu_pool_window.md
Name: relu_pool_window

Overview:
- Upstream neighbour of the max-pool/FC stage.
- Accepts the ReLU feature-map stream: one pixel per transfer, all CH channels in parallel, raster order over an IMG_H x IMG_W frame.
- Buffers one row and assembles non-overlapping 2x2 windows per channel.
- Presents each window, with its window row/column indices, to the pool stage's window inputs and count_x/count_y.

Parameters:
- DATA_W, 69, signed sample width per channel.
- CH, 8, channels per pixel.
- IMG_W, 24, frame width in pixels (even).
- IMG_H, 24, frame height in pixels (even).
- RELU_EN, 1, when 1, negative input samples are replaced by 0 before buffering.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- start  in  1  single-cycle pulse; arms capture of one frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel this cycle.
- in_data  in  CH*DATA_W  pixel; channel c at [c*DATA_W +: DATA_W], signed.
- win_valid  out  1  one-cycle pulse, new window on win_* and counts.
- win_00  out  CH*DATA_W  top-left sample per channel (same channel packing).
- win_01  out  CH*DATA_W  top-right sample per channel.
- win_10  out  CH*DATA_W  bottom-left sample per channel.
- win_11  out  CH*DATA_W  bottom-right sample per channel.
- count_x  out  5  window row index, 0..IMG_H/2-1.
- count_y  out  5  window column index, 0..IMG_W/2-1.
- frame_done  out  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; row/col counters and prev-pixel register cleared.
  - All outputs go to 0: in_ready, win_valid, all win_*, count_x, count_y, frame_done.
  - Line-buffer contents are not cleared (don't care).
- State machine:
  - IDLE: in_ready=0. start=1 -> RUN; row=0, col=0, count_x=0, count_y=0.
  - RUN: in_ready=1. A transfer occurs when in_valid&&in_ready. Acceptance of the last pixel (row IMG_H-1, col IMG_W-1) -> DONE.
  - DONE: single cycle; in_ready=0; returns to IDLE.
  - start is ignored outside IDLE.
  - There is no input backpressure inside RUN.
- ReLU: with RELU_EN=1, each channel sample below zero becomes 0. Value 0 and positive values pass unchanged. With RELU_EN=0, samples pass through untouched. No width change.
- Column/row counters:
  - col increments per transfer and wraps IMG_W-1 -> 0 with row+1.
  - Counters do not advance without a transfer; in_valid gaps of any length are allowed.
- Buffering:
  - On each transfer in an even row, the pixel is written to linebuf[col].
  - On every transfer, the pixel is also written to the prev register.
- Window emission:
  - Triggered by a transfer at odd row r and odd col c.
  - In the next cycle: win_00=linebuf[c-1], win_01=linebuf[c], win_10=prev (pixel r,c-1), win_11=current pixel.
  - In the same cycle: count_x=r>>1, count_y=c>>1, win_valid=1.
  - Latency is 1 cycle from the accepting edge.
- Output hold: win_*, count_x, count_y hold their values between windows. After the last window they hold (IMG_H/2-1, IMG_W/2-1) = (11,11) until the next start or reset. The pool stage latches completion on this.
- frame_done asserts in the same cycle as the final win_valid.
- Reset mid-frame: any partial frame is abandoned, no window is emitted, and a fresh start is required.
- Rate: at most one window every 2 cycles (odd columns only). IMG_H*IMG_W/4 = 144 windows per frame.

Test Plan:
- Ramp frame, no gaps:
  - Stimulus: reset, start, 576 back-to-back pixels, every channel carrying value = 24*r+c.
  - Required: 144 win_valid pulses, each 1 cycle after its odd/odd pixel. Window (0,0) = 0,1,24,25. Window (11,11) = 550,551,574,575. frame_done coincides with the last pulse. Counts then hold at 11,11 and in_ready=0.
- ReLU clamp:
  - Stimulus: channel 3 = -5 and channel 0 = +7 at every pixel, RELU_EN=1.
  - Required: channel 3 of every win_* = 0; channel 0 = 7.
  - With RELU_EN=0: channel 3 = -5 (sign preserved over 69 bits).
- Channel packing:
  - Stimulus: distinct value c*1000+pixel index per channel.
  - Required: each channel lands in its own DATA_W slice of every win_* with no crosstalk.
- Random in_valid gaps:
  - Stimulus: 50% random idle cycles across the frame.
  - Required: identical window contents and order as the gap-free run; no win_valid during idle cycles except the 1-cycle-latency pulse.
- Protocol edges:
  - Stimulus: in_valid=1 while IDLE; start pulsed during RUN.
  - Required: no transfer in IDLE and no counter change; the mid-frame start is ignored.
- Mid-frame reset:
  - Stimulus: rst=0 asynchronously after 300 pixels, then restart a full frame.
  - Required: all outputs 0 immediately; the new frame's first window (0,0) is correct with no stale-data mixing.
